controle_exibicao_sequencia: RTL



---
 rtl/controle_exibicao_sequencia.sv | 132 +++++++++++++
 1 files changed

// File: rtl/controle_exibicao_sequencia.sv
// Plays back the stored color sequence: for each address 0..limite it reads memory,
// shows the word on the LEDs for T_ON cycles, then blanks them for T_OFF cycles.
module controle_exibicao_sequencia #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int T_ON   = 500,
    parameter int T_OFF  = 250
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              abortar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [DATA_W-1:0] dado_memoria,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              ocupado,
    output logic              fim_sequencia,
    output logic [3:0]        db_estado
);

    localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] ON_ULTIMO  = TW'(T_ON - 1);
    localparam logic [TW-1:0] OFF_ULTIMO = TW'(T_OFF - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LE      = 3'd1,
        ACESO   = 3'd2,
        APAGADO = 3'd3,
        FIM     = 3'd4
    } estado_t;

    estado_t           estado;
    estado_t           estado_prox;
    logic [ADDR_W-1:0] limite_reg;
    logic [TW-1:0]     timer;
    logic              fim_on;
    logic              fim_off;
    logic              ultimo_elem;

    assign fim_on      = (timer == ON_ULTIMO);
    assign fim_off     = (timer == OFF_ULTIMO);
    assign ultimo_elem = (endereco == limite_reg);

    // Handshake with the control unit: iniciar is a request honoured only in IDLE;
    // ocupado stays high until the single-cycle fim_sequencia pulse (or an abort).
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= IDLE;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        unique case (estado)
            IDLE:    if (iniciar) estado_prox = LE;
            LE:      estado_prox = ACESO;
            ACESO:   if (fim_on) estado_prox = ultimo_elem ? FIM : APAGADO;
            APAGADO: if (fim_off) estado_prox = LE;
            FIM:     estado_prox = IDLE;
            default: estado_prox = IDLE;
        endcase
        if (abortar) begin
            estado_prox = IDLE;
        end
    end

    // Address, LED and timer registers; abort wins over every other update.
    always_ff @(posedge clock) begin
        if (reset) begin
            endereco   <= '0;
            leds       <= '0;
            limite_reg <= '0;
            timer      <= '0;
        end else if (abortar) begin
            endereco <= '0;
            leds     <= '0;
            timer    <= '0;
        end else begin
            unique case (estado)
                IDLE: begin
                    endereco <= '0;
                    leds     <= '0;
                    timer    <= '0;
                    if (iniciar) begin
                        limite_reg <= limite;
                    end
                end
                LE: begin
                    leds  <= dado_memoria;
                    timer <= '0;
                end
                ACESO: begin
                    if (fim_on) begin
                        leds  <= '0;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                APAGADO: begin
                    // Compare-before-increment keeps the last address from wrapping.
                    if (fim_off) begin
                        endereco <= endereco + 1'b1;
                        timer    <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                FIM: begin
                    endereco <= '0;
                    leds     <= '0;
                end
                default: begin
                    endereco <= '0;
                    leds     <= '0;
                    timer    <= '0;
                end
            endcase
        end
    end

    assign ocupado       = (estado != IDLE);
    assign fim_sequencia = (estado == FIM);
    assign db_estado     = {1'b0, estado};

endmodule
